// File: rtl/icache_pkg.sv
// Shared types and constants for the direct-mapped instruction cache.
package icache_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    GAP,
    RESPOND
  } icache_state_t;

  localparam logic [1:0] WRITE_SIZE_NONE = 2'b00;

endpackage

// File: rtl/icache_data_array.sv
// Line data storage for the instruction cache: one synchronous write port and
// one combinational read port. Contents are never reset.
module icache_data_array #(
  parameter int BITSIZE = 32,
  parameter int DEPTH   = 64,
  parameter int AW      = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               we,
  input  logic [AW-1:0]      waddr,
  input  logic [BITSIZE-1:0] wdata,
  input  logic [AW-1:0]      raddr,
  output logic [BITSIZE-1:0] rdata
);

  logic [BITSIZE-1:0] mem_reg [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem_reg[waddr] <= wdata;
  end

  assign rdata = mem_reg[raddr];

endmodule

// File: rtl/icache.sv
// Direct-mapped, read-only instruction cache refilling whole lines word by word.
// Define ICACHE_PERF_EN to add hit/miss performance counters.
module icache
  import icache_pkg::*;
#(
  parameter int BITSIZE    = 32,
  parameter int N_LINES    = 16,
  parameter int LINE_WORDS = 4
) (
  input  logic               clk,
  input  logic               resetn_i,
  input  logic               core_req_i,
  input  logic [31:0]        core_addr_i,
  input  logic               flush_i,
  output logic [BITSIZE-1:0] core_data_o,
  output logic               core_valid_o,
  output logic [31:0]        mem_address_o,
  output logic               mem_read_o,
  output logic               mem_write_o,
  output logic [1:0]         mem_write_size_o,
  input  logic [BITSIZE-1:0] mem_data_i,
  input  logic               mem_done_i
`ifdef ICACHE_PERF_EN
  ,
  output logic [31:0]        hit_cnt_o,
  output logic [31:0]        miss_cnt_o
`endif
);

  localparam int OFF_W = $clog2(LINE_WORDS);
  localparam int IDX_W = $clog2(N_LINES);
  localparam int TAG_W = 30 - OFF_W - IDX_W;
  localparam logic [OFF_W-1:0] LAST_WORD = OFF_W'(LINE_WORDS - 1);

  icache_state_t      state_reg, state_next;
  logic [OFF_W-1:0]   cnt_reg;
  logic [31:2]        addr_reg;
  logic [BITSIZE-1:0] resp_reg;
  logic [N_LINES-1:0] valid_reg;
  logic [TAG_W-1:0]   tag_reg [N_LINES];
  logic               flush_pend_reg;

  logic [OFF_W-1:0]   req_off, cur_off;
  logic [IDX_W-1:0]   req_idx, cur_idx;
  logic [TAG_W-1:0]   req_tag, cur_tag;
  logic               hit;
  logic [BITSIZE-1:0] rd_data;
  logic               unused_addr_bits;

  assign req_off = core_addr_i[OFF_W+1:2];
  assign req_idx = core_addr_i[OFF_W+IDX_W+1:OFF_W+2];
  assign req_tag = core_addr_i[31:OFF_W+IDX_W+2];
  assign cur_off = addr_reg[OFF_W+1:2];
  assign cur_idx = addr_reg[OFF_W+IDX_W+1:OFF_W+2];
  assign cur_tag = addr_reg[31:OFF_W+IDX_W+2];
  assign unused_addr_bits = ^core_addr_i[1:0];

  assign hit = valid_reg[req_idx] && (tag_reg[req_idx] == req_tag);

  assign mem_write_o      = 1'b0;
  assign mem_write_size_o = WRITE_SIZE_NONE;

  icache_data_array #(
    .BITSIZE (BITSIZE),
    .DEPTH   (N_LINES * LINE_WORDS)
  ) u_data (
    .clk   (clk),
    .we    ((state_reg == FETCH) && mem_done_i),
    .waddr ({cur_idx, cnt_reg}),
    .wdata (mem_data_i),
    .raddr ({req_idx, req_off}),
    .rdata (rd_data)
  );

  always_ff @(posedge clk or negedge resetn_i) begin
    if (!resetn_i) begin
      state_reg      <= IDLE;
      cnt_reg        <= '0;
      addr_reg       <= '0;
      resp_reg       <= '0;
      valid_reg      <= '0;
      flush_pend_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (flush_i && (state_reg != IDLE)) flush_pend_reg <= 1'b1;
      case (state_reg)
        IDLE: begin
          if (flush_i) begin
            valid_reg <= '0;
          end else if (core_req_i) begin
            addr_reg <= core_addr_i[31:2];
            cnt_reg  <= '0;
            if (hit) resp_reg <= rd_data;
          end
        end
        FETCH: begin
          // Capture the requested word as it streams past the refill.
          if (mem_done_i && (cnt_reg == cur_off)) resp_reg <= mem_data_i;
        end
        GAP: begin
          cnt_reg <= cnt_reg + 1'b1;
          if (cnt_reg == LAST_WORD) valid_reg[cur_idx] <= 1'b1;
        end
        RESPOND: begin
          // A flush seen during the refill also kills the line just filled.
          if (flush_i || flush_pend_reg) valid_reg <= '0;
          flush_pend_reg <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if ((state_reg == GAP) && (cnt_reg == LAST_WORD)) tag_reg[cur_idx] <= cur_tag;
  end

  always_comb begin
    state_next    = state_reg;
    mem_read_o    = 1'b0;
    mem_address_o = '0;
    core_valid_o  = 1'b0;
    core_data_o   = '0;
    case (state_reg)
      IDLE: begin
        if (core_req_i && !flush_i) state_next = hit ? RESPOND : FETCH;
      end
      FETCH: begin
        mem_read_o    = 1'b1;
        mem_address_o = {cur_tag, cur_idx, cnt_reg, 2'b00};
        if (mem_done_i) state_next = GAP;
      end
      GAP: begin
        state_next = (cnt_reg == LAST_WORD) ? RESPOND : FETCH;
      end
      RESPOND: begin
        core_valid_o = 1'b1;
        core_data_o  = resp_reg;
        state_next   = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

`ifdef ICACHE_PERF_EN
  always_ff @(posedge clk or negedge resetn_i) begin
    if (!resetn_i) begin
      hit_cnt_o  <= '0;
      miss_cnt_o <= '0;
    end else if ((state_reg == IDLE) && core_req_i && !flush_i) begin
      if (hit) hit_cnt_o <= hit_cnt_o + 1'b1;
      else     miss_cnt_o <= miss_cnt_o + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_icache.sv
// Directed self-checking bench for icache; memory answers after 2 cycles with
// data {16'hC0DE, addr[15:0]}. Checks perf counters when ICACHE_PERF_EN is set.
module tb_icache;

  logic        clk = 1'b0;
  logic        resetn_i = 1'b0;
  logic        core_req_i = 1'b0;
  logic [31:0] core_addr_i = '0;
  logic        flush_i = 1'b0;
  logic [31:0] core_data_o;
  logic        core_valid_o;
  logic [31:0] mem_address_o;
  logic        mem_read_o;
  logic        mem_write_o;
  logic [1:0]  mem_write_size_o;
  logic [31:0] mem_data_i = '0;
  logic        mem_done_i = 1'b0;
`ifdef ICACHE_PERF_EN
  logic [31:0] hit_cnt_o;
  logic [31:0] miss_cnt_o;
`endif

  int total = 0;
  int bad = 0;
  int reads = 0;
  int wait_cnt = 0;
  logic [31:0] rd_log[$];

  icache dut (
    .clk              (clk),
    .resetn_i         (resetn_i),
    .core_req_i       (core_req_i),
    .core_addr_i      (core_addr_i),
    .flush_i          (flush_i),
    .core_data_o      (core_data_o),
    .core_valid_o     (core_valid_o),
    .mem_address_o    (mem_address_o),
    .mem_read_o       (mem_read_o),
    .mem_write_o      (mem_write_o),
    .mem_write_size_o (mem_write_size_o),
    .mem_data_i       (mem_data_i),
    .mem_done_i       (mem_done_i)
`ifdef ICACHE_PERF_EN
    ,
    .hit_cnt_o        (hit_cnt_o),
    .miss_cnt_o       (miss_cnt_o)
`endif
  );

  always #5 clk = ~clk;

  // Memory responder: done on the second cycle of each read request.
  always @(negedge clk) begin
    if (!resetn_i) begin
      mem_done_i = 1'b0;
      wait_cnt = 0;
    end else if (mem_read_o && !mem_done_i) begin
      wait_cnt++;
      if (wait_cnt == 2) begin
        mem_done_i = 1'b1;
        mem_data_i = {16'hC0DE, mem_address_o[15:0]};
        reads++;
        rd_log.push_back(mem_address_o);
      end
    end else begin
      mem_done_i = 1'b0;
      wait_cnt = 0;
      mem_data_i = 32'hDEAD_BEEF;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // mode 0: plain request; 1: flush together with request; 2: flush in third FETCH
  task automatic do_req(input logic [31:0] a, input int mode,
                        output logic [31:0] d, output int cyc, output int nrd);
    int r0;
    bit got;
    bit fl_done;
    r0 = reads;
    rd_log.delete();
    core_addr_i = a;
    core_req_i = 1'b1;
    flush_i = (mode == 1);
    got = 0;
    fl_done = 0;
    cyc = 0;
    d = 'x;
    while (!got && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
      flush_i = 1'b0;
      if (core_valid_o) begin
        got = 1;
        d = core_data_o;
      end else if (mode == 2 && !fl_done && mem_read_o && mem_address_o[3:0] == 4'h8) begin
        flush_i = 1'b1;
        fl_done = 1;
      end
    end
    core_req_i = 1'b0;
    chk("response_seen", 32'(got), 32'd1);
    @(posedge clk); #1;
    nrd = reads - r0;
  endtask

  initial begin
    logic [31:0] d;
    int cyc;
    int nrd;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 32'(core_valid_o), 32'd0);
    chk("rst_data", core_data_o, 32'h0);
    chk("rst_mem_read", 32'(mem_read_o), 32'd0);
    chk("rst_mem_addr", mem_address_o, 32'h0);
    chk("mem_write", 32'(mem_write_o), 32'd0);
    chk("mem_write_size", 32'(mem_write_size_o), 32'd0);
    resetn_i = 1'b1;
    @(posedge clk); #1;

    // Cold miss
    do_req(32'h10, 0, d, cyc, nrd);
    chk("cold_latency", 32'(cyc), 32'd13);
    chk("cold_data", d, 32'hC0DE_0010);
    chk("cold_reads", 32'(nrd), 32'd4);
    if (rd_log.size() == 4) begin
      chk("cold_rd0", rd_log[0], 32'h10);
      chk("cold_rd1", rd_log[1], 32'h14);
      chk("cold_rd2", rd_log[2], 32'h18);
      chk("cold_rd3", rd_log[3], 32'h1C);
    end

    // Hit in the same line
    do_req(32'h14, 0, d, cyc, nrd);
    chk("hit_latency", 32'(cyc), 32'd1);
    chk("hit_data", d, 32'h C0DE_0014);
    chk("hit_reads", 32'(nrd), 32'd0);

    // Request held through RESPOND: back-to-back hits every 2 cycles
    core_addr_i = 32'h18;
    core_req_i = 1'b1;
    @(posedge clk); #1;
    chk("b2b_valid1", 32'(core_valid_o), 32'd1);
    chk("b2b_data1", core_data_o, 32'hC0DE_0018);
    @(posedge clk); #1;
    chk("b2b_gap_valid", 32'(core_valid_o), 32'd0);
    chk("b2b_gap_data", core_data_o, 32'h0);
    @(posedge clk); #1;
    chk("b2b_valid2", 32'(core_valid_o), 32'd1);
    chk("b2b_data2", core_data_o, 32'hC0DE_0018);
    core_req_i = 1'b0;
    @(posedge clk); #1;

    // Conflict on index 1
    do_req(32'h110, 0, d, cyc, nrd);
    chk("conf_data", d, 32'hC0DE_0110);
    chk("conf_reads", 32'(nrd), 32'd4);
    do_req(32'h10, 0, d, cyc, nrd);
    chk("evict_latency", 32'(cyc), 32'd13);
    chk("evict_reads", 32'(nrd), 32'd4);
    chk("evict_data", d, 32'hC0DE_0010);

    // Flush during third FETCH of a refill
    do_req(32'h24, 2, d, cyc, nrd);
    chk("fl_mid_data", d, 32'hC0DE_0024);
    chk("fl_mid_latency", 32'(cyc), 32'd13);
    chk("fl_mid_reads", 32'(nrd), 32'd4);
    do_req(32'h24, 0, d, cyc, nrd);
    chk("fl_mid_after_reads", 32'(nrd), 32'd4);
    chk("fl_mid_after_data", d, 32'hC0DE_0024);

    // Flush with request in IDLE: request ignored this cycle, then misses
    do_req(32'h24, 1, d, cyc, nrd);
    chk("fl_idle_latency", 32'(cyc), 32'd14);
    chk("fl_idle_reads", 32'(nrd), 32'd4);
    chk("fl_idle_data", d, 32'hC0DE_0024);

    // Asynchronous reset during FETCH
    core_addr_i = 32'h50;
    core_req_i = 1'b1;
    cyc = 0;
    while (!mem_read_o && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("fetch_reached", 32'(mem_read_o), 32'd1);
    resetn_i = 1'b0;
    #1;
    chk("rst_fetch_read", 32'(mem_read_o), 32'd0);
    chk("rst_fetch_addr", mem_address_o, 32'h0);
    core_req_i = 1'b0;
    @(posedge clk); #1;
    resetn_i = 1'b1;
    @(posedge clk); #1;

    // Asynchronous reset during GAP
    core_addr_i = 32'h40;
    core_req_i = 1'b1;
    cyc = 0;
    while (!mem_done_i && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("gap_reached", 32'(mem_read_o), 32'd0);
    resetn_i = 1'b0;
    #1;
    chk("rst_gap_read", 32'(mem_read_o), 32'd0);
    chk("rst_gap_valid", 32'(core_valid_o), 32'd0);
    core_req_i = 1'b0;
    @(posedge clk); #1;
    resetn_i = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("post_rst_idle", 32'(mem_read_o), 32'd0);

    // Miss / hit / hit after reset
    do_req(32'h40, 0, d, cyc, nrd);
    chk("post_rst_reads", 32'(nrd), 32'd4);
    chk("post_rst_data", d, 32'hC0DE_0040);
    do_req(32'h44, 0, d, cyc, nrd);
    chk("hit44_reads", 32'(nrd), 32'd0);
    chk("hit44_data", d, 32'hC0DE_0044);
    do_req(32'h48, 0, d, cyc, nrd);
    chk("hit48_data", d, 32'hC0DE_0048);
`ifdef ICACHE_PERF_EN
    chk("perf_hits", hit_cnt_o, 32'd2);
    chk("perf_misses", miss_cnt_o, 32'd1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/icache.md
ICACHE -- requirements
Module: icache

Interface
REQ-001 SHALL have parameter BITSIZE, default 32, data word width.
REQ-002 SHALL have parameter N_LINES, default 16, number of direct-mapped lines (power of two, >=2).
REQ-003 SHALL have parameter LINE_WORDS, default 4, words per line (power of two, >=2).
REQ-004 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-005 SHALL have port resetn_i  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port core_req_i  input  1  fetch request, held until core_valid_o.
REQ-007 SHALL have port core_addr_i  input  32  byte address, word-aligned, held with core_req_i.
REQ-008 SHALL have port flush_i  input  1  invalidate all lines.
REQ-009 SHALL have port core_data_o  output  BITSIZE  fetched word.
REQ-010 SHALL have port core_valid_o  output  1  one-cycle response strobe.
REQ-011 SHALL have port mem_address_o  output  32  accessor address toward memory controller.
REQ-012 SHALL have port mem_read_o  output  1  accessor read request.
REQ-013 SHALL have port mem_write_o  output  1  accessor write, constant 0.
REQ-014 SHALL have port mem_write_size_o  output  2  accessor write size, constant 2'b00.
REQ-015 SHALL have port mem_data_i  input  BITSIZE  accessor read data.
REQ-016 SHALL have port mem_done_i  input  1  accessor completion, valid for mem_data_i.

Function
REQ-017 SHALL split address: bits[1:0] ignored, word offset log2(LINE_WORDS), index log2(N_LINES), tag = remaining upper bits.
REQ-018 SHALL implement FSM states IDLE, FETCH, GAP, RESPOND.
REQ-019 IDLE: on core_req_i with valid line and tag match (hit) SHALL latch word, go RESPOND.
REQ-020 IDLE: on core_req_i miss SHALL clear word counter, go FETCH.
REQ-021 FETCH: SHALL drive mem_read_o=1, mem_address_o={tag,index,counter,2'b00}, held stable until mem_done_i.
REQ-022 FETCH with mem_done_i SHALL write mem_data_i to line word[counter], go GAP.
REQ-023 GAP: mem_read_o=0 for exactly one cycle; counter+1; if counter was LINE_WORDS-1 SHALL set valid/tag, go RESPOND, else FETCH.
REQ-024 RESPOND: core_valid_o=1 with requested word for exactly one cycle, then IDLE.
REQ-025 Hit latency SHALL be 1 cycle (request sampled edge N, valid in cycle N+1); throughput one response per 2 cycles.
REQ-026 Miss latency SHALL be sum over LINE_WORDS words of (memory latency + 1) plus 1 cycle.
REQ-027 core_req_i still high in RESPOND cycle SHALL be treated as a new request in the following IDLE.
REQ-028 flush_i in IDLE SHALL clear all valid bits in one cycle; simultaneous core_req_i SHALL be ignored that cycle and re-evaluated next cycle (miss).
REQ-029 flush_i during FETCH/GAP/RESPOND SHALL be recorded pending; refill and response complete normally; all valid bits (incl. new line) cleared on return to IDLE.
REQ-030 mem_done_i outside FETCH SHALL be ignored.
REQ-031 core_data_o SHALL be 0 when core_valid_o=0.

Reset
REQ-032 resetn_i low SHALL asynchronously force IDLE, all valid bits 0, counter 0, pending flush 0, core_valid_o=0, core_data_o=0, mem_read_o=0, mem_address_o=0.
REQ-033 Reset mid-refill SHALL abandon the refill; line data contents need not be cleared.

Configuration
REQ-034 Macro ICACHE_PERF_EN defined SHALL add outputs hit_cnt_o and miss_cnt_o (32 bits each), incremented once per IDLE hit/miss decision, wrap at 2^32, reset to 0.
REQ-035 Without ICACHE_PERF_EN ports and counters SHALL be absent; all other behaviour identical.

Structure
REQ-036 Package icache_pkg SHALL hold state enum icache_state_t and constants WRITE_SIZE_NONE (2'b00).
REQ-037 Sub-module icache_data_array SHALL hold N_LINES*LINE_WORDS words: one synchronous write port, one combinational read port; tags/valids stay in icache.

Verification
REQ-038 Cold read 0x0000_0010 with memory latency 2 -> reads 0x10,0x14,0x18,0x1C in order, core_valid_o after 13 cycles, data = mem[0x10].
REQ-039 Repeat 0x0000_0014 after REQ-038 -> no mem_read_o, core_valid_o 1 cycle later, data = mem[0x14].
REQ-040 Read 0x0000_0110 (same index, other tag; defaults) -> refill, then 0x0000_0010 misses again.
REQ-041 flush_i during third FETCH of a refill -> response delivered correctly, next read of same address misses.
REQ-042 resetn_i low during GAP -> mem_read_o 0 immediately, next request of same line misses.
REQ-043 ICACHE_PERF_EN defined, sequence miss/hit/hit -> hit_cnt_o=2, miss_cnt_o=1.
